// File: rtl/pdu_dmem_port_master.sv
// pdu_dmem_port_master
// Initiator side of the PDU data-memory port. Turns block read/write commands
// into single-word DMEM cycles and returns read words on a valid/ready stream,
// absorbing the DMEM one-cycle registered-read latency.

module pdu_dmem_port_master #(
    parameter int DEPTH = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [DEPTH-1:0] cmd_addr,
    input  logic [DEPTH-1:0] cmd_len,
    // write data stream
    input  logic [31:0]      wdata_in,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    // read data stream
    output logic [31:0]      rdata_out,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    // status
    output logic             busy,
    output logic             done,
    // DMEM side
    output logic [DEPTH-1:0] interface_addr,
    input  logic [31:0]      interface_rdata,
    output logic [31:0]      interface_wdata,
    output logic             interface_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_CAP,
        S_RD_OUT,
        S_WR,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [DEPTH-1:0] cur_addr;
    logic [DEPTH-1:0] cur_addr_d;
    logic [DEPTH-1:0] remaining;
    logic [DEPTH-1:0] remaining_d;
    logic [31:0]      rdata_out_d;
    logic             rdata_valid_d;

    // State register; a reset mid-burst simply drops back to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Burst address/count and the read holding register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cur_addr    <= '0;
            remaining   <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
        end else begin
            cur_addr    <= cur_addr_d;
            remaining   <= remaining_d;
            rdata_out   <= rdata_out_d;
            rdata_valid <= rdata_valid_d;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state;
        cur_addr_d    = cur_addr;
        remaining_d   = remaining;
        rdata_out_d   = rdata_out;
        rdata_valid_d = rdata_valid;
        cmd_ready     = 1'b0;
        wdata_ready   = 1'b0;
        interface_we  = 1'b0;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_write ? S_WR : S_RD_REQ;
                end
            end

            // Address is already on interface_addr; DMEM registers it this edge.
            S_RD_REQ: begin
                state_d = S_RD_CAP;
            end

            S_RD_CAP: begin
                rdata_out_d   = interface_rdata;
                rdata_valid_d = 1'b1;
                state_d       = S_RD_OUT;
            end

            S_RD_OUT: begin
                if (rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    if (remaining == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cur_addr_d  = cur_addr + DEPTH'(1);
                        remaining_d = remaining - DEPTH'(1);
                        state_d     = S_RD_REQ;
                    end
                end
            end

            // Write enable follows wdata_valid directly so DMEM commits on the
            // same edge that consumes the word.
            S_WR: begin
                wdata_ready  = 1'b1;
                interface_we = wdata_valid;
                if (wdata_valid) begin
                    if (remaining == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cur_addr_d  = cur_addr + DEPTH'(1);
                        remaining_d = remaining - DEPTH'(1);
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address always reflects cur_addr so DMEM never sees a glitch between words.
    assign interface_addr  = cur_addr;
    assign interface_wdata = wdata_in;
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_pdu_dmem_port_master.sv
// Testbench for pdu_dmem_port_master: DMEM model with registered read, a
// word-array reference image, and randomized valid/ready traffic.

module tb_pdu_dmem_port_master;

    localparam int DEPTH = 12;
    localparam int WORDS = 1 << DEPTH;

    logic             sys_clk;
    logic             sys_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [DEPTH-1:0] cmd_addr;
    logic [DEPTH-1:0] cmd_len;
    logic [31:0]      wdata_in;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [31:0]      rdata_out;
    logic             rdata_valid;
    logic             rdata_ready;
    logic             busy;
    logic             done;
    logic [DEPTH-1:0] interface_addr;
    logic [31:0]      interface_rdata;
    logic [31:0]      interface_wdata;
    logic             interface_we;

    int checks;
    int errors;

    logic [31:0] dmem    [WORDS];
    logic [31:0] ref_mem [WORDS];

    pdu_dmem_port_master #(.DEPTH(DEPTH)) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wdata_in        (wdata_in),
        .wdata_valid     (wdata_valid),
        .wdata_ready     (wdata_ready),
        .rdata_out       (rdata_out),
        .rdata_valid     (rdata_valid),
        .rdata_ready     (rdata_ready),
        .busy            (busy),
        .done            (done),
        .interface_addr  (interface_addr),
        .interface_rdata (interface_rdata),
        .interface_wdata (interface_wdata),
        .interface_we    (interface_we)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // DMEM model: synchronous write, registered read.
    always @(posedge sys_clk) begin
        if (interface_we === 1'b1) dmem[interface_addr] <= interface_wdata;
        interface_rdata <= dmem[interface_addr];
    end

    function automatic logic [DEPTH-1:0] wrap_addr(input logic [DEPTH-1:0] base, input int off);
        return DEPTH'((int'(base) + off) % WORDS);
    endfunction

    // One command, start to finish. Expected addresses are base+k mod 2^DEPTH,
    // expected read words come from the reference image, and when all
    // handshakes are forced the exact cycle timing is checked too.
    task automatic run_cmd(input bit wr, input logic [DEPTH-1:0] addr, input logic [DEPTH-1:0] len,
                           input int valid_pct, input int ready_pct, input int stall,
                           input bit poke, input string name);
        int nwords, sent, got, cyc, bound, stall_left;
        bit finished, full_rate, was_stalled;
        logic [31:0] word;
        logic [DEPTH-1:0] ea;
        nwords      = int'(len) + 1;
        sent        = 0;
        got         = 0;
        cyc         = 0;
        stall_left  = stall;
        finished    = 1'b0;
        was_stalled = 1'b0;
        full_rate   = (valid_pct >= 100) && (ready_pct >= 100) && (stall == 0);
        bound       = nwords * 40 + 50;
        word        = $urandom;

        @(negedge sys_clk);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_addr    = addr;
        cmd_len     = len;
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: cmd_ready=%b busy=%b, required 1 0", name, cmd_ready, busy);
        end

        while (!finished && cyc < bound) begin
            @(negedge sys_clk);
            cyc++;
            if (poke) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                cmd_write = ~wr;
                cmd_addr  = DEPTH'($urandom);
                cmd_len   = DEPTH'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            wdata_in    = word;
            wdata_valid = ($urandom_range(1, 100) <= valid_pct);
            if (rdata_valid === 1'b1 && stall_left > 0) begin
                rdata_ready = 1'b0;
                stall_left--;
            end else begin
                rdata_ready = ($urandom_range(1, 100) <= ready_pct);
            end
            #1;

            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy@%0d: cmd_ready=%b busy=%b, required 0 1", name, cyc, cmd_ready, busy);
            end

            if (done === 1'b1) begin
                finished = 1'b1;
                checks++;
                if ((wr ? sent : got) != nwords) begin
                    errors++;
                    $display("FAIL %s done_count: words=%0d, required %0d", name, wr ? sent : got, nwords);
                end
                ea = wrap_addr(addr, nwords - 1);
                checks++;
                if (interface_addr !== ea || interface_we !== 1'b0 || wdata_ready !== 1'b0 || rdata_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_outputs: addr=%h we=%b wready=%b rvalid=%b, required %h 0 0 0",
                             name, interface_addr, interface_we, wdata_ready, rdata_valid, ea);
                end
                if (full_rate) begin
                    checks++;
                    if (cyc != (wr ? nwords + 1 : 3 * nwords + 1)) begin
                        errors++;
                        $display("FAIL %s done_cycle: cycle=%0d, required %0d", name, cyc,
                                 wr ? nwords + 1 : 3 * nwords + 1);
                    end
                end
            end else if ((wr && sent >= nwords) || (!wr && got >= nwords)) begin
                finished = 1'b1;
                checks++;
                errors++;
                $display("FAIL %s missing_done: done=%b after all %0d words, required 1", name, done, nwords);
            end else if (wr) begin
                ea = wrap_addr(addr, sent);
                checks++;
                if (interface_addr !== ea || wdata_ready !== 1'b1 || interface_we !== wdata_valid) begin
                    errors++;
                    $display("FAIL %s wr_ctrl@%0d: addr=%h wready=%b we=%b, required %h 1 %b",
                             name, cyc, interface_addr, wdata_ready, interface_we, ea, wdata_valid);
                end
                if (wdata_valid) begin
                    checks++;
                    if (interface_wdata !== word) begin
                        errors++;
                        $display("FAIL %s wr_data@%0d: wdata=%h, required %h", name, cyc, interface_wdata, word);
                    end
                    ref_mem[ea] = word;
                    sent++;
                    word = $urandom;
                    if (full_rate) begin
                        checks++;
                        if (cyc != sent) begin
                            errors++;
                            $display("FAIL %s wr_rate: word %0d at cycle %0d, required %0d", name, sent, cyc, sent);
                        end
                    end
                end
            end else begin
                ea = wrap_addr(addr, got);
                checks++;
                if (interface_addr !== ea || wdata_ready !== 1'b0 || interface_we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s rd_ctrl@%0d: addr=%h wready=%b we=%b, required %h 0 0",
                             name, cyc, interface_addr, wdata_ready, interface_we, ea);
                end
                if (full_rate) begin
                    checks++;
                    if (rdata_valid !== (cyc % 3 == 0)) begin
                        errors++;
                        $display("FAIL %s rd_spacing@%0d: rdata_valid=%b, required %b", name, cyc,
                                 rdata_valid, (cyc % 3 == 0));
                    end
                end
                if (was_stalled) begin
                    checks++;
                    if (rdata_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL %s stall_hold@%0d: rdata_valid=%b, required 1", name, cyc, rdata_valid);
                    end
                end
                if (rdata_valid === 1'b1) begin
                    checks++;
                    if (rdata_out !== ref_mem[ea]) begin
                        errors++;
                        $display("FAIL %s rd_data@%0d: rdata_out=%h, required %h", name, cyc, rdata_out, ref_mem[ea]);
                    end
                    if (rdata_ready) begin
                        got++;
                        was_stalled = 1'b0;
                    end else begin
                        was_stalled = 1'b1;
                    end
                end
            end
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles, required done", name, bound);
        end

        @(negedge sys_clk);
        cmd_valid   = 1'b0;
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_idle: busy=%b done=%b cmd_ready=%b, required 0 0 1", name, busy, done, cmd_ready);
        end
    endtask

    task automatic test_reset();
        sys_rst     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_in    = '0;
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b cmd_ready=%b wready=%b, required 0 0 1 0",
                     busy, done, cmd_ready, wdata_ready);
        end
        checks++;
        if (rdata_valid !== 1'b0 || rdata_out !== 32'h0 || interface_addr !== '0 || interface_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: rvalid=%b rdata=%h addr=%h we=%b, required 0 0 0 0",
                     rdata_valid, rdata_out, interface_addr, interface_we);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Stray wdata_valid / rdata_ready in IDLE must do nothing.
    task automatic test_idle_ignores();
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            wdata_valid = 1'b1;
            wdata_in    = $urandom;
            rdata_ready = 1'b1;
            #1;
            checks++;
            if (busy !== 1'b0 || interface_we !== 1'b0 || wdata_ready !== 1'b0 || rdata_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: busy=%b we=%b wready=%b rvalid=%b, required 0 0 0 0",
                         busy, interface_we, wdata_ready, rdata_valid);
            end
        end
        @(negedge sys_clk);
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
    endtask

    task automatic test_write_burst();
        run_cmd(1'b1, 12'h010, 12'd3, 100, 100, 0, 1'b0, "write_burst");
    endtask

    task automatic test_read_burst();
        run_cmd(1'b0, 12'h010, 12'd3, 100, 100, 0, 1'b0, "read_burst");
    endtask

    task automatic test_read_stall();
        run_cmd(1'b0, 12'h010, 12'd3, 100, 100, 5, 1'b0, "read_stall");
    endtask

    task automatic test_write_wrap();
        run_cmd(1'b1, 12'hFFE, 12'd3, 100, 100, 0, 1'b0, "write_wrap");
        run_cmd(1'b0, 12'hFFE, 12'd3, 100, 100, 0, 1'b0, "read_wrap");
    endtask

    task automatic test_write_gaps();
        run_cmd(1'b1, DEPTH'($urandom), 12'd7, 50, 100, 0, 1'b1, "write_gaps_poke");
        run_cmd(1'b0, DEPTH'($urandom), 12'd5, 100, 40, 0, 1'b1, "read_gaps_poke");
    endtask

    task automatic test_reset_mid_burst();
        logic [DEPTH-1:0] a;
        logic [31:0] w0, w1, w2;
        a  = 12'h200;
        w0 = $urandom;
        w1 = $urandom;
        w2 = ~ref_mem[wrap_addr(a, 2)];
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_len   = 12'd3;
        @(negedge sys_clk);
        cmd_valid   = 1'b0;
        wdata_valid = 1'b1;
        wdata_in    = w0;
        ref_mem[a]  = w0;
        @(negedge sys_clk);
        wdata_in = w1;
        ref_mem[wrap_addr(a, 1)] = w1;
        @(negedge sys_clk);
        wdata_in = w2;
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || interface_we !== 1'b0 || wdata_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ctrl: busy=%b done=%b we=%b wready=%b cmd_ready=%b, required 0 0 0 0 1",
                     busy, done, interface_we, wdata_ready, cmd_ready);
        end
        checks++;
        if (interface_addr !== '0 || rdata_valid !== 1'b0 || rdata_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_data: addr=%h rvalid=%b rdata=%h, required 0 0 0",
                     interface_addr, rdata_valid, rdata_out);
        end
        @(negedge sys_clk);
        sys_rst     = 1'b0;
        wdata_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (dmem[a] !== w0 || dmem[wrap_addr(a, 1)] !== w1 || dmem[wrap_addr(a, 2)] !== ref_mem[wrap_addr(a, 2)]) begin
            errors++;
            $display("FAIL rst_mid_mem: %h %h %h, required %h %h %h", dmem[a], dmem[wrap_addr(a, 1)],
                     dmem[wrap_addr(a, 2)], w0, w1, ref_mem[wrap_addr(a, 2)]);
        end
        run_cmd(1'b0, a, 12'd3, 100, 100, 0, 1'b0, "post_reset_read");
    endtask

    task automatic test_full_depth();
        logic [DEPTH-1:0] a;
        a = DEPTH'($urandom);
        run_cmd(1'b1, a, '1, 100, 100, 0, 1'b0, "write_full_depth");
        run_cmd(1'b0, wrap_addr(a, WORDS - 4), 12'd7, 100, 100, 0, 1'b0, "read_across_start");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_cmd(1'($urandom), DEPTH'($urandom), DEPTH'($urandom_range(0, 15)),
                    $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 3),
                    1'($urandom), "random");
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (dmem[i] !== ref_mem[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL memory_image: %0d words differ, required 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < WORDS; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        test_reset();
        test_idle_ignores();
        test_write_burst();
        test_read_burst();
        test_read_stall();
        test_write_wrap();
        test_write_gaps();
        test_reset_mid_burst();
        test_full_depth();
        test_random();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
